// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results and div_zero hold until the next accepted start.
module seq_divider #(
  parameter int unsigned WIDTH_N = 16,
  parameter int unsigned WIDTH_D = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_zero
);

  localparam int unsigned CW = $clog2(WIDTH_N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      count, count_n;
  logic [WIDTH_D:0]   p, p_n;
  logic [WIDTH_N-1:0] q, q_n;
  logic [WIDTH_D-1:0] dvsr, dvsr_n;
  logic               busy_n, done_n, div_zero_n;
  logic [WIDTH_N-1:0] quotient_n;
  logic [WIDTH_D-1:0] remainder_n;

  logic [WIDTH_D:0]   p_shift, p_step;
  logic [WIDTH_N-1:0] q_step;
  logic               ge;

  // One restoring step on the current partial remainder and shift register
  always_comb begin
    p_shift = {p[WIDTH_D-1:0], q[WIDTH_N-1]};
    ge      = (p_shift >= {1'b0, dvsr});
    p_step  = ge ? (p_shift - {1'b0, dvsr}) : p_shift;
    q_step  = (q << 1) | WIDTH_N'(ge);
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    p_n         = p;
    q_n         = q;
    dvsr_n      = dvsr;
    quotient_n  = quotient;
    remainder_n = remainder;
    div_zero_n  = div_zero;
    case (state)
      IDLE: begin
        if (start) begin
          dvsr_n     = divisor;
          q_n        = dividend;
          p_n        = '0;
          count_n    = '0;
          div_zero_n = 1'b0;
          if (divisor == '0) begin
            state_n     = DONE;
            quotient_n  = '1;
            remainder_n = '0;
            div_zero_n  = 1'b1;
          end else begin
            state_n = CALC;
          end
        end
      end
      CALC: begin
        p_n     = p_step;
        q_n     = q_step;
        count_n = count + CW'(1);
        if (count == CW'(WIDTH_N - 1)) begin
          state_n     = DONE;
          quotient_n  = q_step;
          remainder_n = p_step[WIDTH_D-1:0];
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      p         <= '0;
      q         <= '0;
      dvsr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      p         <= p_n;
      q         <= q_n;
      dvsr      <= dvsr_n;
      busy      <= busy_n;
      done      <= done_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      div_zero  <= div_zero_n;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner sequences, random ops,
// with a result scoreboard popped on every done pulse.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  exp_t sb[$];

  seq_divider #(.WIDTH_N(16), .WIDTH_D(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: compare every done pulse against the oldest pending expectation
  always @(negedge clk) begin
    if (done) begin
      check("busy_with_done", busy, 1);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_zero", div_zero, e.dz);
        if (!e.dz) begin
          check("invariant_qd_plus_r", longint'(quotient) * e.dvs + remainder, e.dvd);
          check("invariant_r_lt_d", (remainder < e.dvs) ? 1 : 0, 1);
        end
      end
    end
  end

  task automatic launch(input logic [15:0] dvd, input logic [7:0] dvs, input bit push);
    exp_t e;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    if (push) begin
      e.dvd = dvd;
      e.dvs = dvs;
      e.dz  = (dvs == 0);
      e.q   = (dvs == 0) ? 16'hFFFF : dvd / 16'(dvs);
      e.r   = (dvs == 0) ? 8'd0 : 8'(dvd % 16'(dvs));
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Latency counted so that a done visible right after the start edge is 1
  task automatic wait_done(output int lat);
    int n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    lat = n + 1;
  endtask

  initial begin
    vec_t vecs[9];
    int   lat;

    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17};
    vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 17};
    vecs[2] = '{16'd3,     8'd200, 16'd0,     8'd3,   1'b0, 17};
    vecs[3] = '{16'd5,     8'd0,   16'hFFFF,  8'd0,   1'b1, 1};
    vecs[4] = '{16'd13,    8'd1,   16'd13,    8'd0,   1'b0, 17};
    vecs[5] = '{16'd255,   8'd255, 16'd1,     8'd0,   1'b0, 17};
    vecs[6] = '{16'd0,     8'd9,   16'd0,     8'd0,   1'b0, 17};
    vecs[7] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 17};
    vecs[8] = '{16'd200,   8'd201, 16'd0,     8'd200, 1'b0, 17};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_div_zero", div_zero, 0);
    rst = 1'b0;

    // Vector table: expected results come straight from the table
    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      dividend = vecs[i].dvd;
      divisor  = vecs[i].dvs;
      start    = 1'b1;
      e = '{vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz};
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      check($sformatf("latency_vec%0d", i), lat, vecs[i].lat);
    end

    // Divide by zero: busy drops the cycle after done, then a new start clears div_zero only
    launch(16'd5, 8'd0, 1);
    wait_done(lat);
    check("dz_latency", lat, 1);
    @(negedge clk);
    check("dz_busy_after", busy, 0);
    check("dz_done_after", done, 0);
    launch(16'd1000, 8'd7, 1);
    check("start_clears_div_zero", div_zero, 0);
    check("start_holds_quotient", quotient, 16'hFFFF);
    check("busy_after_accept", busy, 1);
    wait_done(lat);
    check("latency_after_dz", lat, 17);

    // Start held through the DONE cycle is ignored; only the following IDLE edge accepts it
    launch(16'd65535, 8'd255, 1);
    wait_done(lat);
    dividend = 16'd3; divisor = 8'd200; start = 1'b1;
    sb.push_back('{16'd3, 8'd200, 16'd0, 8'd3, 1'b0});
    @(posedge clk); #1;
    check("start_in_done_ignored_busy", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    check("b2b_accepted_busy", busy, 1);
    wait_done(lat);
    check("b2b_latency", lat, 17);

    // Start during CALC with new operands must not disturb the running division
    launch(16'd1000, 8'd7, 1);
    repeat (4) @(negedge clk);
    dividend = 16'd13; divisor = 8'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dividend = 16'd77; divisor = 8'd3;
    wait_done(lat);
    check("ignored_start_latency", lat, 13);
    repeat (20) @(negedge clk);
    check("no_extra_done_queue", sb.size(), 0);

    // Asynchronous reset mid-CALC aborts with no done pulse
    launch(16'd1000, 8'd7, 1);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_quotient", quotient, 0);
    check("arst_remainder", remainder, 0);
    check("arst_div_zero", div_zero, 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_no_done_pulse", sb.size(), 0);
    launch(16'd13, 8'd1, 1);
    wait_done(lat);
    check("post_reset_latency", lat, 17);

    // Random operations: model from native / and %, latency fixed at 17
    for (int i = 0; i < 500; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      launch(a, b, 1);
      wait_done(lat);
      if (lat != 17) check($sformatf("rand_latency_%0d", i), lat, 17);
    end
    checks++;
    @(negedge clk);
    check("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
